// File: rtl/aes_round_key_sequencer.sv
// aes_round_key_sequencer
//   Captures an AES key schedule and streams it to a round-key consumer.
//   K0 comes from cipher_key on key_start. K1..K(NO_ROUNDS) come from the
//   key generator's W bus, captured when its last per-round valid rises.
//   The stored schedule is streamed over a valid/ready handshake, either
//   ascending (encrypt, K0 first) or descending (decrypt, K(NO_ROUNDS) first).
//
// Parameters
//   DATA_W     round key width
//   NO_ROUNDS  number of expanded round keys carried on W
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   key_start, cipher_key start a new schedule, K0 value
//   W, W_valid            expanded keys (round 1 in the MSBs), per-round valids
//   seq_start, dec_mode   stream request, direction (1 = descending)
//   rk_ready              consumer ready
//   rk_data, rk_idx       current round key and its index
//   rk_valid, rk_last     key valid, final key of the stream
//   keys_loaded, busy     schedule stored, loading or streaming
//
// Build option
//   AES_KEY_ZEROIZE_EN    wipe the schedule after one complete stream and
//                         return to IDLE instead of LOADED
module aes_round_key_sequencer #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned NO_ROUNDS = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          key_start,
  input  logic [DATA_W-1:0]             cipher_key,
  input  logic [NO_ROUNDS*DATA_W-1:0]   W,
  input  logic [NO_ROUNDS-1:0]          W_valid,
  input  logic                          seq_start,
  input  logic                          dec_mode,
  input  logic                          rk_ready,
  output logic [DATA_W-1:0]             rk_data,
  output logic                          rk_valid,
  output logic [3:0]                    rk_idx,
  output logic                          rk_last,
  output logic                          keys_loaded,
  output logic                          busy
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned NKEYS = NO_ROUNDS + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_ROUNDS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_KEYS = 2'd1,
    LOADED    = 2'd2,
    STREAM    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  keys_q [NKEYS];
  logic               dec_q, dec_d;

  logic [DATA_W-1:0]  rk_data_d;
  logic               rk_valid_d;
  logic [IDX_W-1:0]   rk_idx_d;
  logic               rk_last_d;
  logic               keys_loaded_d;
  logic               busy_d;

  logic               load_k0;
  logic               load_w;
  logic               clear_keys;

  logic [IDX_W-1:0]   fetch_idx;
  logic [DATA_W-1:0]  fetch_key;

  // Only the top W_valid bit matters; the rest are deliberately ignored.
  logic unused_w_valid;
  assign unused_w_valid = ^W_valid;

  // Index of the key that would be presented next: the stream's first key
  // when starting from LOADED, otherwise the neighbour of the current one.
  always_comb begin
    fetch_idx = '0;
    if (state_q == LOADED) begin
      fetch_idx = dec_mode ? LAST_IDX : '0;
    end else if (dec_q) begin
      fetch_idx = rk_idx - IDX_W'(1);
    end else begin
      fetch_idx = rk_idx + IDX_W'(1);
    end
  end

  assign fetch_key = keys_q[fetch_idx];

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    dec_d         = dec_q;
    rk_data_d     = rk_data;
    rk_valid_d    = rk_valid;
    rk_idx_d      = rk_idx;
    rk_last_d     = rk_last;
    keys_loaded_d = keys_loaded;
    load_k0       = 1'b0;
    load_w        = 1'b0;
    clear_keys    = 1'b0;

    if (key_start) begin
      // New schedule wins over everything, including an active stream.
      load_k0       = 1'b1;
      state_d       = WAIT_KEYS;
      keys_loaded_d = 1'b0;
      rk_valid_d    = 1'b0;
      rk_data_d     = '0;
      rk_idx_d      = '0;
      rk_last_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        WAIT_KEYS: begin
          if (W_valid[NO_ROUNDS-1]) begin
            load_w        = 1'b1;
            state_d       = LOADED;
            keys_loaded_d = 1'b1;
          end
        end
        LOADED: begin
          if (seq_start) begin
            dec_d      = dec_mode;
            state_d    = STREAM;
            rk_valid_d = 1'b1;
            rk_data_d  = fetch_key;
            rk_idx_d   = fetch_idx;
            rk_last_d  = 1'b0;
          end
        end
        STREAM: begin
          if (rk_valid && rk_ready) begin
            if (rk_last) begin
              rk_valid_d = 1'b0;
              rk_data_d  = '0;
              rk_idx_d   = '0;
              rk_last_d  = 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
              state_d       = IDLE;
              keys_loaded_d = 1'b0;
              clear_keys    = 1'b1;
`else
              state_d       = LOADED;
`endif
            end else begin
              rk_data_d = fetch_key;
              rk_idx_d  = fetch_idx;
              rk_last_d = dec_q ? (fetch_idx == '0) : (fetch_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == WAIT_KEYS) || (state_d == STREAM);
  end

  // State, output and key storage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dec_q       <= 1'b0;
      rk_data     <= '0;
      rk_valid    <= 1'b0;
      rk_idx      <= '0;
      rk_last     <= 1'b0;
      keys_loaded <= 1'b0;
      busy        <= 1'b0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
        keys_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      rk_data     <= rk_data_d;
      rk_valid    <= rk_valid_d;
      rk_idx      <= rk_idx_d;
      rk_last     <= rk_last_d;
      keys_loaded <= keys_loaded_d;
      busy        <= busy_d;
      if (clear_keys) begin
        for (int unsigned k = 0; k < NKEYS; k++) begin
          keys_q[k] <= '0;
        end
      end else begin
        if (load_k0) begin
          keys_q[0] <= cipher_key;
        end
        // Round r sits r-1 slots down from the MSB end of W.
        if (load_w) begin
          for (int unsigned r = 1; r <= NO_ROUNDS; r++) begin
            keys_q[r] <= W[NO_ROUNDS*DATA_W-1-(r-1)*DATA_W -: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Bench for aes_round_key_sequencer: FIPS-197 schedule plus random schedules,
// random consumer back-pressure, aborts by key_start and by reset.
module tb_aes_round_key_sequencer;

  localparam int unsigned DW = 128;
  localparam int unsigned NR = 10;

  logic              clk;
  logic              reset;
  logic              key_start;
  logic [DW-1:0]     cipher_key;
  logic [NR*DW-1:0]  W;
  logic [NR-1:0]     W_valid;
  logic              seq_start;
  logic              dec_mode;
  logic              rk_ready;
  logic [DW-1:0]     rk_data;
  logic              rk_valid;
  logic [3:0]        rk_idx;
  logic              rk_last;
  logic              keys_loaded;
  logic              busy;

  aes_round_key_sequencer #(.DATA_W(DW), .NO_ROUNDS(NR)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .cipher_key(cipher_key),
    .W(W), .W_valid(W_valid), .seq_start(seq_start), .dec_mode(dec_mode),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rk_last(rk_last), .keys_loaded(keys_loaded), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] fips [0:NR];
  logic [DW-1:0] m_keys [0:NR];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NR*DW-1:0] rand_w();
    logic [NR*DW-1:0] w;
    for (int i = 0; i < NR; i++) w[i*DW +: DW] = rand128();
    return w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, rk_valid, 0);
    check({tag, "_data"},  rk_data,  0);
    check({tag, "_idx"},   rk_idx,   0);
    check({tag, "_last"},  rk_last,  0);
  endtask

  // key_start, a few cycles of partial W_valid, then the full W capture.
  task automatic load_schedule(input bit use_fips);
    logic [DW-1:0] nk [0:NR];
    logic [NR*DW-1:0] w;
    for (int i = 0; i <= NR; i++) nk[i] = use_fips ? fips[i] : rand128();
    key_start = 1'b1; cipher_key = nk[0]; W_valid = '0; W = rand_w();
    tick();
    key_start = 1'b0; cipher_key = rand128();
    check("ld_busy", busy, 1);
    check("ld_loaded", keys_loaded, 0);
    check_idle_outputs("ld");
    repeat ($urandom_range(0, 2)) begin
      W_valid = NR'($urandom) & 10'h1FF; W = rand_w();
      tick();
      check("ld_partial_loaded", keys_loaded, 0);
    end
    for (int r = 1; r <= NR; r++) w[NR*DW-1-(r-1)*DW -: DW] = nk[r];
    W = w; W_valid = 10'h3FF;
    tick();
    W_valid = '0; W = rand_w();
    check("ld_done_loaded", keys_loaded, 1);
    check("ld_done_busy", busy, 0);
    for (int i = 0; i <= NR; i++) m_keys[i] = nk[i];
  endtask

  task automatic expect_ignored(input logic exp_busy);
    seq_start = 1'b1; dec_mode = 1'($urandom); rk_ready = 1'b1;
    tick();
    seq_start = 1'b0;
    check("ign_valid", rk_valid, 0);
    check("ign_busy", busy, exp_busy);
    check("ign_loaded", keys_loaded, 0);
    tick();
    check("ign_valid2", rk_valid, 0);
    rk_ready = 1'b0;
  endtask

  // abort_kind: 0 none, 1 key_start, 2 reset; abort fires at transfer abort_at.
  task automatic run_stream(input bit dec, input int stall_at, input int abort_at, input int abort_kind);
    int order[$];
    int xfers;
    int stall;
    int cyc;
    for (int k = 0; k <= NR; k++) order.push_back(dec ? NR - k : k);
    seq_start = 1'b1; dec_mode = dec; rk_ready = 1'b0;
    tick();
    seq_start = 1'b0; dec_mode = 1'($urandom);
    check("st_busy", busy, 1);
    xfers = 0; stall = 0; cyc = 0;
    while (order.size() > 0 && cyc < 300) begin
      cyc++;
      check("st_valid", rk_valid, 1);
      check("st_idx",  rk_idx,  order[0]);
      check("st_data", rk_data, m_keys[order[0]]);
      check("st_last", rk_last, order.size() == 1);
      if (abort_kind != 0 && xfers == abort_at) begin
        if (abort_kind == 1) begin
          key_start = 1'b1; cipher_key = rand128(); rk_ready = 1'b1;
          tick();
          key_start = 1'b0; rk_ready = 1'b0;
          check("abort_valid", rk_valid, 0);
          check("abort_busy", busy, 1);
          check("abort_loaded", keys_loaded, 0);
        end else begin
          rk_ready = 1'b0;
          reset = 1'b1;
          #1;
          check_idle_outputs("rst_mid");
          check("rst_mid_busy", busy, 0);
          check("rst_mid_loaded", keys_loaded, 0);
          tick();
          reset = 1'b0;
        end
        return;
      end
      if (stall_at == xfers && stall < 5) begin
        rk_ready = 1'b0; stall++;
      end else begin
        rk_ready = ($urandom_range(0, 3) != 0);
      end
      if (rk_ready) begin
        void'(order.pop_front());
        xfers++;
      end
      tick();
    end
    if (order.size() != 0) check("st_timeout", 0, 1);
    rk_ready = 1'b0;
    check_idle_outputs("st_end");
    check("st_end_busy", busy, 0);
`ifdef AES_KEY_ZEROIZE_EN
    check("st_end_loaded", keys_loaded, 0);
`else
    check("st_end_loaded", keys_loaded, 1);
`endif
  endtask

  task automatic after_stream_reload(input bit use_fips);
`ifdef AES_KEY_ZEROIZE_EN
    expect_ignored(1'b0);
    load_schedule(use_fips);
`endif
  endtask

  initial begin
    fips[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    fips[1]  = 128'hd6aa74fdd2af72fafaa678f1d6ab76fe;
    fips[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    fips[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    fips[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    fips[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    fips[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    fips[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    fips[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    fips[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    fips[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    reset = 1'b1; key_start = 1'b0; cipher_key = '0; W = '0; W_valid = '0;
    seq_start = 1'b0; dec_mode = 1'b0; rk_ready = 1'b0;
    tick(); tick();
    check_idle_outputs("rst");
    check("rst_busy", busy, 0);
    check("rst_loaded", keys_loaded, 0);
    reset = 1'b0;
    tick();

    // No stream without a schedule.
    expect_ignored(1'b0);

    // FIPS-197 schedule, decrypt order then replay.
    load_schedule(1'b1);
    run_stream(1'b1, -1, -1, 0);
    after_stream_reload(1'b1);
    run_stream(1'b1, 3, -1, 0);
    after_stream_reload(1'b1);

    // Encrypt order with a 5-cycle stall mid-stream.
    run_stream(1'b0, 4, -1, 0);
    after_stream_reload(1'b0);

    // Random schedules and directions.
    for (int it = 0; it < 6; it++) begin
      load_schedule(1'b0);
      run_stream(1'($urandom), $urandom_range(0, NR), -1, 0);
      after_stream_reload(1'b0);
`ifndef AES_KEY_ZEROIZE_EN
      run_stream(1'($urandom), -1, -1, 0);
`endif
    end

    // Abort by key_start at transfer 4; seq_start ignored until reload.
    load_schedule(1'b0);
    run_stream(1'b0, -1, 4, 1);
    expect_ignored(1'b1);
    load_schedule(1'b0);
    run_stream(1'b1, -1, -1, 0);
    after_stream_reload(1'b0);

    // Reset mid-stream discards the schedule.
    load_schedule(1'b0);
    run_stream(1'b1, -1, 6, 2);
    expect_ignored(1'b0);
    load_schedule(1'b1);
    run_stream(1'b0, 2, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
